// File: rtl/uart_xcvr.sv
// uart_xcvr: parametrised full-duplex UART (5..9 data bits, none/odd/even/mark/space parity, 1-2 stop bits).
// Optional macro UART_XCVR_LOOPBACK_EN adds a loopback input that routes the internal tx into the RX path.
//
// state     | meaning
// IDLE      | line idle; TX waits for a handshake, RX waits for a low sample
// START     | start bit; RX rejects a start that is high again at mid-bit
// DATA      | data bits, LSB first
// PARITY    | parity bit (skipped when PARITY = 0)
// STOP      | TX drives STOP_BITS bit times high; RX samples the first stop bit
module uart_xcvr #(
    parameter int CLK_FREQ     = 100000000,
    parameter int BAUD_RATE    = 115200,
    parameter int OVER_SAMPLES = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
`ifdef UART_XCVR_LOOPBACK_EN
    input  logic                 loopback,
`endif
    input  logic                 rx,
    output logic                 tx,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err,
    output logic                 rx_overrun
);
    localparam int DIV   = (CLK_FREQ + BAUD_RATE * OVER_SAMPLES / 2) / (BAUD_RATE * OVER_SAMPLES);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int OS_W  = $clog2(OVER_SAMPLES);
    localparam logic [DIV_W-1:0] DIV_LAST     = DIV_W'(DIV - 1);
    localparam logic [OS_W-1:0]  OS_LAST      = OS_W'(OVER_SAMPLES - 1);
    localparam logic [OS_W-1:0]  OS_HALF_LAST = OS_W'(OVER_SAMPLES / 2 - 1);
    localparam logic [3:0]       DATA_LAST    = 4'(DATA_BITS - 1);
    localparam logic [3:0]       STOP_LAST    = 4'(STOP_BITS - 1);

    if (DIV < 1) begin : g_bad_div
        $error("uart_xcvr: BAUD_RATE * OVER_SAMPLES too high for CLK_FREQ");
    end
    if (OVER_SAMPLES < 4 || (OVER_SAMPLES % 2) != 0) begin : g_bad_os
        $error("uart_xcvr: OVER_SAMPLES must be even and >= 4");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
        $error("uart_xcvr: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 4) begin : g_bad_par
        $error("uart_xcvr: PARITY must be 0..4");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_xcvr: STOP_BITS must be 1 or 2");
    end

    function automatic logic par_bit(input logic [DATA_BITS-1:0] d);
        case (PARITY)
            1:       par_bit = ~^d;
            2:       par_bit = ^d;
            3:       par_bit = 1'b1;
            default: par_bit = 1'b0;
        endcase
    endfunction

    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;

    logic             rst_done;
    logic [DIV_W-1:0] div_cnt;
    logic             tick;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rst_done <= 1'b0;
            div_cnt  <= '0;
        end else begin
            rst_done <= 1'b1;
            div_cnt  <= tick ? DIV_LAST : div_cnt - 1'b1;
        end
    end

    assign tick = (div_cnt == '0);

    // ---------------- transmitter ----------------
    state_t                tx_state, tx_state_nxt;
    logic [OS_W-1:0]       tx_tcnt, tx_tcnt_nxt;
    logic [3:0]            tx_bidx, tx_bidx_nxt;
    logic [DATA_BITS-1:0]  tx_shift, tx_shift_nxt;
    logic                  tx_par, tx_par_nxt;
    logic                  tx_line;
    logic                  tx_bit_end;

    assign tx_ready   = (tx_state == ST_IDLE) && rst_done;
    assign tx_bit_end = tick && (tx_tcnt == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_state <= ST_IDLE;
            tx_tcnt  <= '0;
            tx_bidx  <= '0;
            tx_shift <= '0;
            tx_par   <= 1'b0;
        end else begin
            tx_state <= tx_state_nxt;
            tx_tcnt  <= tx_tcnt_nxt;
            tx_bidx  <= tx_bidx_nxt;
            tx_shift <= tx_shift_nxt;
            tx_par   <= tx_par_nxt;
        end
    end

    always_comb begin
        tx_state_nxt = tx_state;
        tx_tcnt_nxt  = tx_tcnt;
        tx_bidx_nxt  = tx_bidx;
        tx_shift_nxt = tx_shift;
        tx_par_nxt   = tx_par;
        tx_line      = 1'b1;
        if (tick) begin
            tx_tcnt_nxt = (tx_tcnt == '0) ? OS_LAST : tx_tcnt - 1'b1;
        end
        case (tx_state)
            ST_IDLE: begin
                if (tx_valid && tx_ready) begin
                    tx_state_nxt = ST_START;
                    tx_tcnt_nxt  = OS_LAST;
                    tx_shift_nxt = tx_data;
                    tx_par_nxt   = par_bit(tx_data);
                end
            end
            ST_START: begin
                tx_line = 1'b0;
                if (tx_bit_end) begin
                    tx_state_nxt = ST_DATA;
                    tx_bidx_nxt  = '0;
                end
            end
            ST_DATA: begin
                tx_line = tx_shift[0];
                if (tx_bit_end) begin
                    if (tx_bidx == DATA_LAST) begin
                        tx_state_nxt = (PARITY == 0) ? ST_STOP : ST_PARITY;
                        tx_bidx_nxt  = '0;
                    end else begin
                        tx_shift_nxt = tx_shift >> 1;
                        tx_bidx_nxt  = tx_bidx + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                tx_line = tx_par;
                if (tx_bit_end) begin
                    tx_state_nxt = ST_STOP;
                    tx_bidx_nxt  = '0;
                end
            end
            ST_STOP: begin
                if (tx_bit_end) begin
                    if (tx_bidx == STOP_LAST) tx_state_nxt = ST_IDLE;
                    else                      tx_bidx_nxt  = tx_bidx + 1'b1;
                end
            end
            default: tx_state_nxt = ST_IDLE;
        endcase
    end

    // ---------------- receiver ----------------
    logic rx_src;

`ifdef UART_XCVR_LOOPBACK_EN
    assign rx_src = loopback ? tx_line : rx;
    assign tx     = loopback ? 1'b1 : tx_line;
`else
    assign rx_src = rx;
    assign tx     = tx_line;
`endif

    logic [1:0]            rx_sync;
    logic                  rx_s;
    state_t                rx_state, rx_state_nxt;
    logic [OS_W-1:0]       rx_tcnt, rx_tcnt_nxt;
    logic [3:0]            rx_bidx, rx_bidx_nxt;
    logic [DATA_BITS-1:0]  rx_shift, rx_shift_nxt;
    logic                  rx_par, rx_par_nxt;
    logic                  rx_sample;
    logic                  frame_done;
    logic                  accept;
    logic                  perr_new;

    assign rx_s      = rx_sync[1];
    assign rx_sample = tick && (rx_tcnt == '0);
    assign accept    = rx_valid && rx_ready;
    assign perr_new  = (PARITY != 0) && (rx_par != par_bit(rx_shift));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_sync  <= 2'b11;
            rx_state <= ST_IDLE;
            rx_tcnt  <= '0;
            rx_bidx  <= '0;
            rx_shift <= '0;
            rx_par   <= 1'b0;
        end else begin
            rx_sync  <= {rx_sync[0], rx_src};
            rx_state <= rx_state_nxt;
            rx_tcnt  <= rx_tcnt_nxt;
            rx_bidx  <= rx_bidx_nxt;
            rx_shift <= rx_shift_nxt;
            rx_par   <= rx_par_nxt;
        end
    end

    always_comb begin
        rx_state_nxt = rx_state;
        rx_tcnt_nxt  = rx_tcnt;
        rx_bidx_nxt  = rx_bidx;
        rx_shift_nxt = rx_shift;
        rx_par_nxt   = rx_par;
        frame_done   = 1'b0;
        if (tick) begin
            rx_tcnt_nxt = (rx_tcnt == '0) ? OS_LAST : rx_tcnt - 1'b1;
        end
        case (rx_state)
            ST_IDLE: begin
                if (tick && !rx_s) begin
                    rx_state_nxt = ST_START;
                    rx_tcnt_nxt  = OS_HALF_LAST;
                end
            end
            ST_START: begin
                if (rx_sample) begin
                    rx_state_nxt = rx_s ? ST_IDLE : ST_DATA;
                    rx_bidx_nxt  = '0;
                end
            end
            ST_DATA: begin
                if (rx_sample) begin
                    rx_shift_nxt = {rx_s, rx_shift[DATA_BITS-1:1]};
                    if (rx_bidx == DATA_LAST) rx_state_nxt = (PARITY == 0) ? ST_STOP : ST_PARITY;
                    else                      rx_bidx_nxt  = rx_bidx + 1'b1;
                end
            end
            ST_PARITY: begin
                if (rx_sample) begin
                    rx_par_nxt   = rx_s;
                    rx_state_nxt = ST_STOP;
                end
            end
            ST_STOP: begin
                if (rx_sample) begin
                    frame_done   = 1'b1;
                    rx_state_nxt = ST_IDLE;
                end
            end
            default: rx_state_nxt = ST_IDLE;
        endcase
    end

    // A frame finishing while the held one is still pending is dropped and flagged.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            rx_parity_err <= 1'b0;
            rx_frame_err  <= 1'b0;
            rx_overrun    <= 1'b0;
        end else begin
            if (frame_done && (!rx_valid || rx_ready)) begin
                rx_data       <= rx_shift;
                rx_parity_err <= perr_new;
                rx_frame_err  <= ~rx_s;
                rx_valid      <= 1'b1;
            end else if (accept) begin
                rx_valid <= 1'b0;
            end
            if (accept) begin
                rx_overrun <= 1'b0;
            end else if (frame_done && rx_valid) begin
                rx_overrun <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_uart_xcvr.sv
// Bench for uart_xcvr: an 8N1 instance (a) for TX timing and an 8E2 instance (b) for RX/status,
// both at 16 clocks per bit; expected TX bits and RX frames flow through scoreboard queues.
module tb_uart_xcvr;
    logic clk;
    logic rst_n;

    logic       rx_a;
    logic       tx_a;
    logic [7:0] tx_data_a;
    logic       tx_valid_a;
    logic       tx_ready_a;
    logic [7:0] rx_data_a;
    logic       rx_valid_a;
    logic       rx_ready_a;
    logic       rx_parity_err_a;
    logic       rx_frame_err_a;
    logic       rx_overrun_a;

    logic       rx_b;
    logic       rx_drv_b;
    logic       ext_lb;
    logic       tx_b;
    logic [7:0] tx_data_b;
    logic       tx_valid_b;
    logic       tx_ready_b;
    logic [7:0] rx_data_b;
    logic       rx_valid_b;
    logic       rx_ready_b;
    logic       rx_parity_err_b;
    logic       rx_frame_err_b;
    logic       rx_overrun_b;
`ifdef UART_XCVR_LOOPBACK_EN
    logic       lb_a;
    logic       lb_b;
`endif

    int   n_checks;
    int   n_fail;
    int   n_rx_acc;
    logic tx_mon_en;
    logic       tx_exp[$];
    logic [9:0] rx_exp[$];

    assign rx_b = ext_lb ? tx_b : rx_drv_b;

    uart_xcvr #(
        .CLK_FREQ(1600000), .BAUD_RATE(100000), .OVER_SAMPLES(16),
        .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)
    ) u_8n1 (
        .clk(clk), .rst_n(rst_n),
`ifdef UART_XCVR_LOOPBACK_EN
        .loopback(lb_a),
`endif
        .rx(rx_a), .tx(tx_a),
        .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready_a),
        .rx_data(rx_data_a), .rx_valid(rx_valid_a), .rx_ready(rx_ready_a),
        .rx_parity_err(rx_parity_err_a), .rx_frame_err(rx_frame_err_a), .rx_overrun(rx_overrun_a)
    );

    uart_xcvr #(
        .CLK_FREQ(1600000), .BAUD_RATE(100000), .OVER_SAMPLES(16),
        .DATA_BITS(8), .PARITY(2), .STOP_BITS(2)
    ) u_8e2 (
        .clk(clk), .rst_n(rst_n),
`ifdef UART_XCVR_LOOPBACK_EN
        .loopback(lb_b),
`endif
        .rx(rx_b), .tx(tx_b),
        .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b),
        .rx_data(rx_data_b), .rx_valid(rx_valid_b), .rx_ready(rx_ready_b),
        .rx_parity_err(rx_parity_err_b), .rx_frame_err(rx_frame_err_b), .rx_overrun(rx_overrun_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // 8N1 transmit on instance a; expected line bits go to the TX scoreboard.
    task automatic send_a(input logic [7:0] d);
        int lo;
        tx_exp.push_back(1'b0);
        for (int i = 0; i < 8; i++) tx_exp.push_back(d[i]);
        tx_exp.push_back(1'b1);
        check("a_idle_high", tx_a, 1);
        check("a_ready_idle", tx_ready_a, 1);
        tx_data_a  = d;
        tx_valid_a = 1'b1;
        @(negedge clk);
        tx_valid_a = 1'b0;
        tx_data_a  = 8'hxx;
        check("a_low_after_hs", tx_a, 0);
        lo = 0;
        while (!tx_ready_a && lo < 400) begin
            lo++;
            @(negedge clk);
        end
        check("a_ready_low_cycles", lo, 160);
    endtask

    // 8E2 transmit on instance b: start + 8 data + parity + 2 stop = 192 cycles busy.
    task automatic send_b(input logic [7:0] d);
        int lo;
        check("b_ready_idle", tx_ready_b, 1);
        tx_data_b  = d;
        tx_valid_b = 1'b1;
        @(negedge clk);
        tx_valid_b = 1'b0;
        lo = 0;
        while (!tx_ready_b && lo < 500) begin
            lo++;
            @(negedge clk);
        end
        check("b_ready_low_cycles", lo, 192);
    endtask

    // Serial frame into instance b; the expected status is modelled from even parity and the stop level.
    task automatic drive_rx(input logic [7:0] d, input logic par, input logic stp, input bit push);
        if (push) rx_exp.push_back({par != (^d), ~stp, d});
        rx_drv_b = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_drv_b = d[i];
            repeat (16) @(negedge clk);
        end
        rx_drv_b = par;
        repeat (16) @(negedge clk);
        rx_drv_b = stp;
        repeat (16) @(negedge clk);
        rx_drv_b = 1'b1;
        repeat (16) @(negedge clk);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (rx_valid_b && rx_ready_b) begin
                n_rx_acc++;
                check("rx_queue_nonempty", rx_exp.size() > 0, 1);
                if (rx_exp.size() > 0)
                    check("rx_frame", {rx_parity_err_b, rx_frame_err_b, rx_data_b}, rx_exp.pop_front());
            end
        end
    end

    // Samples instance a's line mid-bit, 8 cycles after the start edge then every 16.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (tx_mon_en && tx_a == 1'b0) begin
                for (int b = 0; b < 10; b++) begin
                    repeat ((b == 0) ? 8 : 16) @(negedge clk);
                    #1;
                    check("tx_queue_nonempty", tx_exp.size() > 0, 1);
                    if (tx_exp.size() > 0) check("tx_bit", tx_a, tx_exp.pop_front());
                end
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int acc0;
        int hi_cnt;
        n_checks = 0;
        n_fail   = 0;
        n_rx_acc = 0;
        tx_mon_en  = 1'b0;
        rst_n      = 1'b0;
        rx_a       = 1'b1;
        rx_ready_a = 1'b1;
        tx_data_a  = '0;
        tx_valid_a = 1'b0;
        rx_drv_b   = 1'b1;
        ext_lb     = 1'b0;
        tx_data_b  = '0;
        tx_valid_b = 1'b0;
        rx_ready_b = 1'b0;
`ifdef UART_XCVR_LOOPBACK_EN
        lb_a = 1'b0;
        lb_b = 1'b0;
`endif
        repeat (5) @(negedge clk);
        check("rst_tx_a", tx_a, 1);
        check("rst_tx_b", tx_b, 1);
        check("rst_tx_ready", tx_ready_a, 0);
        check("rst_rx_valid", rx_valid_b, 0);
        check("rst_flags", {rx_parity_err_b, rx_frame_err_b, rx_overrun_b}, 0);
        check("rst_a_rx", {rx_valid_a, rx_parity_err_a, rx_frame_err_a, rx_overrun_a}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready_rise", tx_ready_a, 1);
        tx_mon_en = 1'b1;
        repeat (3) @(negedge clk);

        send_a(8'hA5);
        repeat (4) @(negedge clk);

        rx_ready_b = 1'b1;
        acc0 = n_rx_acc;
        drive_rx(8'h3C, 1'b0, 1'b1, 1);
        check("rx_8e2_count", n_rx_acc, acc0 + 1);

        acc0 = n_rx_acc;
        drive_rx(8'h3C, 1'b1, 1'b0, 1);
        check("rx_err_count", n_rx_acc, acc0 + 1);

        rx_ready_b = 1'b0;
        drive_rx(8'h11, 1'b0, 1'b1, 1);
        drive_rx(8'h22, 1'b0, 1'b1, 0);
        check("ovr_valid", rx_valid_b, 1);
        check("ovr_data", rx_data_b, 8'h11);
        check("ovr_flag", rx_overrun_b, 1);
        rx_ready_b = 1'b1;
        @(negedge clk);
        check("ovr_valid_clr", rx_valid_b, 0);
        check("ovr_flag_clr", rx_overrun_b, 0);

        acc0 = n_rx_acc;
        rx_drv_b = 1'b0;
        repeat (4) @(negedge clk);
        rx_drv_b = 1'b1;
        repeat (300) @(negedge clk);
        check("glitch_no_valid", n_rx_acc, acc0);

        acc0 = n_rx_acc;
        ext_lb = 1'b1;
        rx_exp.push_back({2'b00, 8'hA7});
        send_b(8'hA7);
        repeat (20) @(negedge clk);
        ext_lb = 1'b0;
        check("b_self_loop_count", n_rx_acc, acc0 + 1);

        acc0 = n_rx_acc;
        fork
            send_b(8'h81);
            drive_rx(8'h69, 1'b0, 1'b1, 1);
            send_a(8'h96);
        join
        check("concurrent_count", n_rx_acc, acc0 + 1);
        repeat (10) @(negedge clk);

        tx_mon_en  = 1'b0;
        acc0 = n_rx_acc;
        tx_data_a  = 8'h00;
        tx_valid_a = 1'b1;
        rx_drv_b   = 1'b0;
        @(negedge clk);
        tx_valid_a = 1'b0;
        repeat (47) @(negedge clk);
        rx_drv_b = 1'b1;
        repeat (8) @(negedge clk);
        check("mid_frame_tx_low", tx_a, 0);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_tx_high", tx_a, 1);
        check("mid_rst_ready_low", tx_ready_a, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_rst_ready_rise", tx_ready_a, 1);
        repeat (300) @(negedge clk);
        check("mid_rst_no_rx", n_rx_acc, acc0);
        check("mid_rst_rx_valid", rx_valid_b, 0);
        tx_mon_en = 1'b1;
        @(negedge clk);

        acc0 = n_rx_acc;
        drive_rx(8'hC3, 1'b0, 1'b1, 1);
        check("post_rst_rx_count", n_rx_acc, acc0 + 1);
        send_a(8'h3C);
        repeat (4) @(negedge clk);

`ifdef UART_XCVR_LOOPBACK_EN
        lb_b = 1'b1;
        repeat (4) @(negedge clk);
        acc0 = n_rx_acc;
        hi_cnt = 0;
        rx_exp.push_back({2'b00, 8'h5A});
        fork
            send_b(8'h5A);
            for (int i = 0; i < 200; i++) begin
                @(negedge clk);
                if (tx_b != 1'b1) hi_cnt++;
            end
        join
        repeat (10) @(negedge clk);
        check("lb_tx_pin_high", hi_cnt, 0);
        check("lb_rx_count", n_rx_acc, acc0 + 1);
        lb_b = 1'b0;
`else
        hi_cnt = 0;
`endif

        repeat (4) @(negedge clk);
        check("rx_leftover", rx_exp.size(), 0);
        check("tx_leftover", tx_exp.size(), 0);
        check("a_rx_quiet", rx_valid_a, 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_xcvr.md
Name: uart_xcvr

Overview:
- Parametrised full-duplex UART transceiver; successor to the fixed 8N1 echo UART.
- Generalises data width, parity mode and stop-bit count.
- Adds valid/ready handshakes on both directions, a 2-flop RX synchroniser, false-start rejection, and per-frame parity, framing and overrun status.
- Sits between the pad-level tx/rx pins and the on-chip host logic (CPU bus bridge or debug monitor).

Parameters:
- CLK_FREQ, 100000000: system clock frequency in Hz.
- BAUD_RATE, 115200: line rate in bit/s.
- OVER_SAMPLES, 16: ticks per bit. Must be an even number ≥ 4.
- DATA_BITS, 8: payload bits per frame, legal range 5..9. Sent LSB first.
- PARITY, 0: parity mode. 0 = none, 1 = odd, 2 = even, 3 = mark, 4 = space.
- STOP_BITS, 1: stop bits per frame, 1 or 2.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- rx  in  1  serial input from the pad; asynchronous.
- tx  out  1  serial output to the pad.
- tx_data  in  DATA_BITS  byte to transmit.
- tx_valid  in  1  tx_data is valid.
- tx_ready  out  1  transmitter can accept a byte.
- rx_data  out  DATA_BITS  received byte.
- rx_valid  out  1  rx_data and the error flags are valid.
- rx_ready  in  1  consumer accepts rx_data.
- rx_parity_err  out  1  parity mismatch for the frame held in rx_data.
- rx_frame_err  out  1  first stop bit sampled low for the frame held in rx_data.
- rx_overrun  out  1  sticky: at least one frame was dropped.

Behaviour:
- **Reset (rst_n low at a clk edge):**
  - tx=1, tx_ready=0, rx_valid=0, all error flags 0.
  - Tick counter, both FSMs and the synchroniser are cleared; synchroniser flops are set to 1.
  - tx_ready rises on the first cycle after rst_n is sampled high.
  - Reset mid-frame aborts immediately: tx returns high with no partial stop bit, and the RX frame is discarded.
- **Tick generator:**
  - DIV = (CLK_FREQ + BAUD_RATE*OVER_SAMPLES/2) / (BAUD_RATE*OVER_SAMPLES), i.e. rounded to nearest. Elaboration fails if DIV < 1.
  - A free-running counter 0..DIV-1 produces a 1-cycle tick. It is shared by TX and RX.
  - One bit lasts OVER_SAMPLES ticks.
- **TX FSM (IDLE, START, DATA, PARITY, STOP):**
  - tx_ready=1 only in IDLE.
  - In IDLE, tx_valid && tx_ready at an edge latches tx_data and enters START. tx goes low on the next cycle.
  - Each state holds for OVER_SAMPLES ticks, counted from the first tick after entry.
  - DATA shifts DATA_BITS bits out, LSB first.
  - PARITY is skipped when PARITY=0. Odd: tx = ~^data. Even: tx = ^data. Mark: 1. Space: 0.
  - STOP drives 1 for STOP_BITS bit times, then returns to IDLE.
  - tx_data is don't-care once latched.
- **RX path:**
  - rx passes through a 2-flop synchroniser. All following references to rx mean the synchronised value.
  - IDLE: a low sample on a tick enters START.
  - START: at the OVER_SAMPLES/2-th tick, if rx is high, the event is a false start; return to IDLE with no flag raised.
  - Otherwise, from that mid-start point, sample every OVER_SAMPLES ticks: DATA_BITS data bits, then the parity bit if enabled, then the first stop bit.
  - Second stop bit: not checked.
  - After the stop-bit sample:
    - Load rx_data, rx_parity_err and rx_frame_err into the output holding register.
    - Set rx_valid.
    - Return to IDLE immediately, so a back-to-back start bit is caught.
- **RX handshake:**
  - rx_valid && rx_ready at an edge clears rx_valid on the next cycle.
  - rx_data and the error flags are stable while rx_valid=1.
  - Frame completes while rx_valid=1 and rx_ready=0: the new frame is dropped, the held data is unchanged, and rx_overrun is set.
  - Frame completes in the same cycle as an accept: the new frame is loaded, rx_valid stays 1, and no overrun is raised.
  - rx_overrun clears on the next accepted handshake.
- **Concurrency:** TX and RX are fully independent; simultaneous operation is legal.

Optional Feature:
- Macro: UART_XCVR_LOOPBACK_EN.
- When defined:
  - An extra input port loopback (1 bit) is added.
  - loopback=1 feeds the internal tx into the RX synchroniser in place of the rx pin, and holds the tx pin at 1.
  - Switching loopback mid-frame is not supported; the frame contents are undefined.
- When undefined: no loopback port or logic exists, and RX is always driven by the rx pin.

Test Plan:
(All scenarios use CLK_FREQ=1600000, BAUD_RATE=100000, OVER_SAMPLES=16, giving DIV=1 and 16 cycles per bit.)
- **TX 8N1:**
  - Stimulus: tx_data=0xA5, tx_valid pulsed for 1 cycle after reset.
  - Required response:
    - tx goes low 1 cycle after the handshake.
    - Bits 1,0,1,0,0,1,0,1 follow, each 16 cycles ±1.
    - Then high for 16 cycles.
    - tx_ready low for 160±1 cycles.
- **RX 8E2:**
  - Stimulus: drive rx frame 0x3C with correct even parity (0) and 2 stop bits, rx_ready=1.
  - Required response: rx_valid pulses 1 cycle, rx_data=0x3C, both error flags 0.
- **Error flags:**
  - Stimulus: 0x3C frame with parity bit 1, stop bit 0.
  - Required response: rx_parity_err=1, rx_frame_err=1, rx_data=0x3C.
- **Overrun and false start:**
  - Stimulus:
    - Two back-to-back frames 0x11, 0x22 with rx_ready=0.
    - Then raise rx_ready.
    - Then an isolated 4-cycle low glitch on rx.
  - Required response:
    - rx_data=0x11, rx_overrun=1.
    - Both clear after the accept.
    - The glitch produces no rx_valid.
- **Reset mid-frame:**
  - Stimulus: deassert rst_n for 1 cycle during a TX data bit and an RX data bit.
  - Required response:
    - tx=1 next cycle, tx_ready=1 the cycle after.
    - No rx_valid.
    - A following clean frame is received correctly.
- **Loopback (macro defined):**
  - Stimulus: loopback=1, transmit 0x5A.
  - Required response: rx_data=0x5A, tx pin constant 1.
